// File: rtl/req_arbiter_8_pkg.sv
// Shared definitions for the 8-way fixed-priority request arbiter.
package req_arbiter_8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prio_enc_8.sv
// 8-to-3 priority encoder: highest set index wins, all-zero input encodes to 0.
module prio_enc_8
  import req_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Ascending scan lets the highest set bit overwrite lower ones.
  always_comb begin
    idx = '0;
    any = |req;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/req_arbiter_8.sv
// 8-way fixed-priority arbiter with hold-until-release grants and a dead cycle.
// Define ARB_TIMEOUT_EN to build in the HOLD_MAX starvation guard (tmo / blocked).
module req_arbiter_8
  import req_arbiter_8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_W-1:0]     gnt_id,
  output logic                gnt_valid,
  output logic                tmo
);

  arb_state_e          state;
  logic [NUM_REQ-1:0]  blocked;
  logic [NUM_REQ-1:0]  eff_req;
  logic [ID_W-1:0]     next_owner;
  logic                eff_any;
  logic                hold_expire;

  assign eff_req = req & ~blocked;

  prio_enc_8 u_prio_enc (
    .req (eff_req),
    .idx (next_owner),
    .any (eff_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       tmo_r;

  assign hold_expire = (hold_cnt == 8'(HOLD_MAX - 1));
  assign tmo         = tmo_r;

  // A release on the limit edge wins over the timeout: only a still-held owner is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      blocked  <= '0;
      tmo_r    <= 1'b0;
    end else begin
      tmo_r   <= 1'b0;
      blocked <= blocked & req;
      if (state == IDLE) begin
        hold_cnt <= '0;
      end else if (req[gnt_id]) begin
        if (hold_expire) begin
          tmo_r           <= 1'b1;
          blocked[gnt_id] <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end
`else
  assign hold_expire = 1'b0;
  assign blocked     = '0;
  assign tmo         = 1'b0;
`endif

  // gnt_id doubles as the owner register while in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eff_any) begin
            state             <= GRANT;
            gnt               <= '0;
            gnt[next_owner]   <= 1'b1;
            gnt_id            <= next_owner;
            gnt_valid         <= 1'b1;
          end
        end
        GRANT: begin
          if (!req[gnt_id] || hold_expire) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Scoreboard bench for req_arbiter_8: directed scenarios plus random request traffic.
module tb_req_arbiter_8;

`ifdef ARB_TIMEOUT_EN
  localparam int  HOLD   = 4;
  localparam bit  TMO_EN = 1'b1;
`else
  localparam int  HOLD   = 16;
  localparam bit  TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       tmo;

  always #5 clk = ~clk;

  req_arbiter_8 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .tmo       (tmo)
  );

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  // Reference model: owner = -1 means no grant outstanding.
  int m_owner = -1;
  int m_cnt   = 0;
  bit m_blk[8];
  bit m_tmo   = 1'b0;

  function automatic void model_edge(input logic r, input logic [7:0] rq);
    bit old_blk[8];
    bit found;
    if (r) begin
      m_owner = -1;
      m_cnt   = 0;
      m_tmo   = 1'b0;
      for (int i = 0; i < 8; i++) m_blk[i] = 1'b0;
    end else begin
      m_tmo = 1'b0;
      for (int i = 0; i < 8; i++) begin
        old_blk[i] = m_blk[i];
        if (!rq[i]) m_blk[i] = 1'b0;
      end
      if (m_owner < 0) begin
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
          if (!found && rq[i] && !old_blk[i]) begin
            m_owner = i;
            found   = 1'b1;
          end
        end
        m_cnt = 0;
      end else if (!rq[m_owner]) begin
        m_owner = -1;
      end else if (TMO_EN && m_cnt == HOLD - 1) begin
        m_blk[m_owner] = 1'b1;
        m_tmo          = 1'b1;
        m_owner        = -1;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  task automatic step(input logic r, input logic [7:0] rq);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model_edge(r, rq);
    e.gnt   = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    e.id    = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    e.valid = (m_owner >= 0);
    e.tmo   = m_tmo;
    q.push_back(e);
    n_step++;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, n_step, act, exp);
    end
  endtask

  // Monitor: outputs settle after every edge, so one expectation is consumed per edge.
  initial begin
    exp_t       e;
    logic [2:0] enc;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt",       gnt,             e.gnt);
        check("gnt_id",    {5'd0, gnt_id},  {5'd0, e.id});
        check("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.valid});
        check("tmo",       {7'd0, tmo},     {7'd0, e.tmo});
        check("onehot0",   {7'd0, $onehot0(gnt)}, 8'd1);
        if (gnt != 8'h00) begin
          enc = 3'd0;
          for (int i = 0; i < 8; i++) if (gnt[i]) enc = 3'(i);
          check("id_vs_gnt", {5'd0, gnt_id}, {5'd0, enc});
        end
      end
    end
  end

  initial begin
    logic [7:0] cur;
    logic       r;

    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    repeat (10) step(1'b0, 8'h00);

    // Priority pick, no pre-emption, dead cycle on release.
    step(1'b0, 8'h05);
    repeat (2) step(1'b0, 8'h05);
    repeat (3) step(1'b0, 8'h85);
    repeat (3) step(1'b0, 8'h80);

    // Reset mid-grant, then re-grant.
    step(1'b0, 8'h00);
    repeat (2) step(1'b0, 8'h10);
    step(1'b1, 8'h10);
    repeat (2) step(1'b0, 8'h10);

    // Long hold of two requesters; exercises timeout and blocking when enabled.
    step(1'b0, 8'h00);
    repeat (12) step(1'b0, 8'h03);
    step(1'b0, 8'h01);
    repeat (6) step(1'b0, 8'h03);
    step(1'b0, 8'h00);

    cur = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      end
      if ($urandom_range(0, 49) == 0) cur = 8'h00;
      r = ($urandom_range(0, 199) == 0);
      step(r, cur);
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/req_arbiter_8.md
REQ_ARBITER_8 -- requirements
Module: req_arbiter_8

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum consecutive grant cycles before forced revoke; legal range 2..255.
REQ-002 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, reset; synchronous and active-high.
REQ-004 Port: req, input, 8, level request per requester; requester holds it high for the whole time it uses the resource.
REQ-005 Port: gnt, output, 8, one-hot grant, registered.
REQ-006 Port: gnt_id, output, 3, binary index of the granted requester, registered.
REQ-007 Port: gnt_valid, output, 1, high when any grant is active.
REQ-008 Port: tmo, output, 1, one-cycle pulse on a forced revoke.

Function
REQ-009 FSM has two states: IDLE and GRANT.
REQ-010 Arbitration is fixed-priority: index 7 is highest and index 0 is lowest; it applies only to the effective request vector (req AND NOT blocked).
REQ-011 IDLE: if the effective request vector is non-zero at an edge, go to GRANT and latch owner = highest set index; otherwise stay in IDLE.
REQ-012 Grant latency: req sampled at edge N; gnt, gnt_id and gnt_valid are valid from edge N.
REQ-013 GRANT: gnt = 1 << owner, gnt_id = owner, gnt_valid = 1.
REQ-014 GRANT: requests from any other requester, including higher-priority ones, do not pre-empt the owner.
REQ-015 GRANT: if req[owner] = 0 at an edge, go to IDLE; gnt = 0 for at least one cycle (mandatory dead cycle).
REQ-016 In IDLE, gnt, gnt_id and gnt_valid are all 0.
REQ-017 gnt is one-hot or zero in every cycle, and gnt_id equals the encoded gnt.
REQ-018 All-zero req keeps the FSM in IDLE indefinitely.

Reset
REQ-019 rst = 1 at an edge forces: state IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, tmo = 0, hold counter = 0, blocked = 0.
REQ-020 Reset asserted mid-grant revokes the grant at that edge; no tmo pulse is generated.
REQ-021 Reset has priority over every other event in the same cycle.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN compiles the starvation guard in or out.
REQ-023 With ARB_TIMEOUT_EN defined:
- An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
- When the counter = HOLD_MAX-1 and req[owner] is still 1, the FSM goes to IDLE and tmo pulses for one cycle.
- blocked[owner] is then set.
REQ-024 blocked[i] clears at any edge where req[i] = 0.
REQ-025 A blocked requester cannot win arbitration; if it is the only requester, no grant is issued.
REQ-026 Normal release at the same edge as the limit is not a timeout: tmo stays 0 and blocked is not set.
REQ-027 Without ARB_TIMEOUT_EN: no counter and no blocked register; tmo is tied 0; a grant is held until release; HOLD_MAX is ignored.

Structure
REQ-028 A shared package holds:
- the state enum (IDLE, GRANT);
- the constant NUM_REQ = 8;
- the owner index width of 3.
REQ-029 Sub-module prio_enc_8: combinational 8-to-3 priority encoder (MSB wins, all-zero yields 0) computing the next owner from the effective request vector; this is the only sub-module.

Verification
REQ-030 req = 8'h00 for 10 cycles after reset -> gnt_valid = 0 and gnt = 0 throughout.
REQ-031 req = 8'h05 at edge N -> at edge N gnt = 8'h04, gnt_id = 2.
REQ-032 Owner 2 held; req[7] rises -> gnt remains 8'h04 (no pre-emption).
REQ-033 req[2] drops at edge M -> gnt = 0 for cycle M; gnt = 8'h80, gnt_id = 7 from edge M+1.
REQ-034 ARB_TIMEOUT_EN, HOLD_MAX = 4, req = 8'h03 held:
- gnt = 8'h02 for 4 cycles;
- then tmo = 1 and gnt = 0 for one cycle;
- then gnt = 8'h01, while requester 1 stays blocked until req[1] drops.
REQ-035 rst pulsed while gnt = 8'h10 -> next cycle all outputs are 0; re-grant follows REQ-012.
